// File: rtl/led_pattern_gen_pkg.sv
// Shared encodings for the LED pattern engine.
// Mode codes, pattern states and PWM width.
package led_pkg;

  localparam logic [1:0] MODE_BAR   = 2'd0;
  localparam logic [1:0] MODE_DOT   = 2'd1;
  localparam logic [1:0] MODE_SHIFT = 2'd2;
  localparam logic [1:0] MODE_OFF   = 2'd3;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DOWN  = 2'd2,
    ST_UP    = 2'd3
  } state_t;

  localparam int PWM_W = 4;

endpackage

// File: rtl/led_pattern_gen_if.sv
// Control/status bundle of the LED pattern engine.
// LED_PWM_EN adds the brightness input.
interface led_pattern_gen_if
  import led_pkg::*;
#(
  parameter int N_LED = 8,
  parameter int DIV_W = 24
);

  logic             en;
  logic [1:0]       mode;
  logic [DIV_W-1:0] period;
  logic [N_LED-1:0] led;
  logic             step_pulse;
  logic             wrap;
`ifdef LED_PWM_EN
  logic [PWM_W-1:0] brightness;

  modport master (
    output en, mode, period, brightness,
    input  led, step_pulse, wrap
  );

  modport slave (
    input  en, mode, period, brightness,
    output led, step_pulse, wrap
  );
`else
  modport master (
    output en, mode, period,
    input  led, step_pulse, wrap
  );

  modport slave (
    input  en, mode, period,
    output led, step_pulse, wrap
  );
`endif

endinterface

// File: rtl/led_pattern_gen_step_tick_gen.sv
// Programmable prescaler: one tick every period+1 enabled cycles.
// Comparing with >= lets a lowered period take effect at once.
module step_tick_gen #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  localparam logic [DIV_W-1:0] ONE = 1;

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  assign tick = en && (cnt_q >= period);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern engine: bar fill/drain, bouncing dot, rotating dot.
// Optional LED_PWM_EN dims the LEDs with a 4-bit PWM.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int N_LED = 8,
  parameter int DIV_W = 24
) (
  input logic clk,
  input logic nrst,
  led_pattern_gen_if.slave bus
);

  localparam int PW = $clog2(N_LED + 1);

  localparam logic [PW-1:0]    ONE  = 1;
  localparam logic [PW-1:0]    TOP  = PW'(N_LED - 1);
  localparam logic [PW-1:0]    FULL = PW'(N_LED);
  localparam logic [N_LED-1:0] LSB  = 1;
  localparam logic [N_LED-1:0] ALL  = '1;

  logic [1:0]       mode_q;
  state_t           state_q, state_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic [N_LED-1:0] led_q, led_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             mode_chg;
  logic             tick;

  assign mode_chg = (bus.mode != mode_q);

  step_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk    (clk),
    .nrst   (nrst),
    .en     (bus.en),
    .clr    (mode_chg),
    .period (bus.period),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    led_d   = led_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    if (mode_chg) begin
      // A mode change reloads the pattern and swallows any due tick.
      unique case (bus.mode)
        MODE_DOT, MODE_SHIFT: begin
          state_d = ST_DOWN;
          pos_d   = TOP;
          led_d   = LSB << TOP;
        end
        default: begin
          state_d = ST_FILL;
          pos_d   = '0;
          led_d   = '0;
        end
      endcase
    end else if (tick && mode_q != MODE_OFF) begin
      step_d = 1'b1;
      if (mode_q == MODE_SHIFT) begin
        if (pos_q == '0) begin
          pos_d  = TOP;
          wrap_d = 1'b1;
        end else begin
          pos_d = pos_q - ONE;
        end
        led_d = LSB << pos_d;
      end else begin
        unique case (state_q)
          ST_FILL: begin
            pos_d = pos_q + ONE;
            if (pos_d == FULL) state_d = ST_DRAIN;
            led_d = ~(ALL >> pos_d);
          end
          ST_DRAIN: begin
            pos_d = pos_q - ONE;
            if (pos_d == '0) begin
              state_d = ST_FILL;
              wrap_d  = 1'b1;
            end
            led_d = ~(ALL >> pos_d);
          end
          ST_DOWN: begin
            pos_d = pos_q - ONE;
            if (pos_d == '0) state_d = ST_UP;
            led_d = LSB << pos_d;
          end
          ST_UP: begin
            pos_d = pos_q + ONE;
            if (pos_d == TOP) begin
              state_d = ST_DOWN;
              wrap_d  = 1'b1;
            end
            led_d = LSB << pos_d;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mode_q  <= MODE_BAR;
      state_q <= ST_FILL;
      pos_q   <= '0;
      led_q   <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      mode_q  <= bus.mode;
      state_q <= state_d;
      pos_q   <= pos_d;
      led_q   <= led_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.step_pulse = step_q;
  assign bus.wrap       = wrap_q;

`ifdef LED_PWM_EN
  logic [PWM_W-1:0] pwm_cnt_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
    end
  end

  assign bus.led = led_q & {N_LED{pwm_cnt_q < bus.brightness}};
`else
  assign bus.led = led_q;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with N_LED=8.
// Hand-computed expected values, immediate assertions.
module tb_led_pattern_gen;

  logic clk;
  logic nrst;
  int   n_chk;
  int   n_pass;

  led_pattern_gen_if #(.N_LED(8), .DIV_W(24)) bus ();

  led_pattern_gen #(
    .N_LED (8),
    .DIV_W (24)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  logic [7:0] bar_seq [17];
  logic [7:0] dot_seq [14];
  logic [7:0] sh_seq  [4];
  int         on_cnt;

  initial begin
    bar_seq = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC,
                8'hFE, 8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0,
                8'hE0, 8'hC0, 8'h80, 8'h00, 8'h80};
    dot_seq = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02,
                8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                8'h40, 8'h80};
    sh_seq  = '{8'h08, 8'h04, 8'h02, 8'h01};
    n_chk   = 0;
    n_pass  = 0;
    clk     = 1'b0;
    nrst    = 1'b0;
    bus.en     = 1'b1;
    bus.mode   = 2'd0;
    bus.period = '0;
`ifdef LED_PWM_EN
    bus.brightness = 4'd15;
`endif

    // reset state
    #12;
    chk("rst_led", 32'(bus.led), 32'h00);
    chk("rst_step", 32'(bus.step_pulse), 32'h0);
    chk("rst_wrap", 32'(bus.wrap), 32'h0);
    nrst = 1'b1;

    // BAR, period 0
    for (int i = 0; i < 17; i++) begin
      tick_n(1);
      chk($sformatf("bar_led%0d", i), 32'(bus.led), 32'(bar_seq[i]));
      chk($sformatf("bar_step%0d", i), 32'(bus.step_pulse), 32'h1);
      chk($sformatf("bar_wrap%0d", i), 32'(bus.wrap), 32'(i == 15));
    end

    // DOT, period 3
    bus.mode   = 2'd1;
    bus.period = 24'd3;
    tick_n(1);
    chk("dot_load_led", 32'(bus.led), 32'h80);
    chk("dot_load_step", 32'(bus.step_pulse), 32'h0);
    chk("dot_load_wrap", 32'(bus.wrap), 32'h0);
    for (int i = 0; i < 14; i++) begin
      tick_n(3);
      chk($sformatf("dot_idle%0d", i), 32'(bus.step_pulse), 32'h0);
      tick_n(1);
      chk($sformatf("dot_led%0d", i), 32'(bus.led), 32'(dot_seq[i]));
      chk($sformatf("dot_step%0d", i), 32'(bus.step_pulse), 32'h1);
      chk($sformatf("dot_wrap%0d", i), 32'(bus.wrap), 32'(i == 13));
    end

    // SHIFT, period 0, en low for 5 cycles at 0x10
    bus.mode   = 2'd2;
    bus.period = '0;
    tick_n(1);
    chk("sh_load_led", 32'(bus.led), 32'h80);
    chk("sh_load_step", 32'(bus.step_pulse), 32'h0);
    tick_n(3);
    chk("sh_pre_led", 32'(bus.led), 32'h10);
    bus.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick_n(1);
      chk($sformatf("sh_hold_led%0d", i), 32'(bus.led), 32'h10);
      chk($sformatf("sh_hold_step%0d", i), 32'(bus.step_pulse), 32'h0);
    end
    bus.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick_n(1);
      chk($sformatf("sh_led%0d", i), 32'(bus.led), 32'(sh_seq[i]));
      chk($sformatf("sh_wrap%0d", i), 32'(bus.wrap), 32'h0);
    end
    tick_n(1);
    chk("sh_rot_led", 32'(bus.led), 32'h80);
    chk("sh_rot_step", 32'(bus.step_pulse), 32'h1);
    chk("sh_rot_wrap", 32'(bus.wrap), 32'h1);

    // BAR, long period shortened mid-count
    bus.mode   = 2'd0;
    bus.period = 24'd1000;
    tick_n(1);
    chk("per_load_led", 32'(bus.led), 32'h00);
    tick_n(500);
    chk("per_wait_step", 32'(bus.step_pulse), 32'h0);
    chk("per_wait_led", 32'(bus.led), 32'h00);
    bus.period = 24'd10;
    tick_n(1);
    chk("per_now_led", 32'(bus.led), 32'h80);
    chk("per_now_step", 32'(bus.step_pulse), 32'h1);
    tick_n(10);
    chk("per_gap_step", 32'(bus.step_pulse), 32'h0);
    tick_n(1);
    chk("per_t2_led", 32'(bus.led), 32'hC0);
    chk("per_t2_step", 32'(bus.step_pulse), 32'h1);
    tick_n(10);
    chk("per_gap2_step", 32'(bus.step_pulse), 32'h0);
    tick_n(1);
    chk("per_t3_led", 32'(bus.led), 32'hE0);

    // mode change on a due tick
    bus.mode   = 2'd2;
    bus.period = 24'd2;
    tick_n(1);
    chk("mc_load_led", 32'(bus.led), 32'h80);
    tick_n(2);
    chk("mc_idle_step", 32'(bus.step_pulse), 32'h0);
    tick_n(1);
    chk("mc_t1_led", 32'(bus.led), 32'h40);
    tick_n(2);
    bus.mode = 2'd0;
    tick_n(1);
    chk("mc_chg_led", 32'(bus.led), 32'h00);
    chk("mc_chg_step", 32'(bus.step_pulse), 32'h0);
    chk("mc_chg_wrap", 32'(bus.wrap), 32'h0);
    tick_n(2);
    chk("mc_cnt_step", 32'(bus.step_pulse), 32'h0);
    tick_n(1);
    chk("mc_next_led", 32'(bus.led), 32'h80);
    chk("mc_next_step", 32'(bus.step_pulse), 32'h1);

    // async reset mid-DRAIN
    bus.period = '0;
    tick_n(8);
    chk("dr_led", 32'(bus.led), 32'hFE);
    nrst = 1'b0;
    #1;
    chk("ar_led", 32'(bus.led), 32'h00);
    chk("ar_step", 32'(bus.step_pulse), 32'h0);
    nrst = 1'b1;
    tick_n(1);
    chk("ar_rel_led", 32'(bus.led), 32'h80);
    chk("ar_rel_step", 32'(bus.step_pulse), 32'h1);

    // OFF
    bus.mode = 2'd3;
    tick_n(1);
    chk("off_load_led", 32'(bus.led), 32'h00);
    tick_n(3);
    chk("off_led", 32'(bus.led), 32'h00);
    chk("off_step", 32'(bus.step_pulse), 32'h0);
    chk("off_wrap", 32'(bus.wrap), 32'h0);

`ifdef LED_PWM_EN
    bus.mode       = 2'd2;
    bus.en         = 1'b0;
    bus.brightness = 4'd4;
    tick_n(1);
    on_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick_n(1);
      if (bus.led == 8'h80) on_cnt++;
    end
    chk("pwm4_on", 32'(on_cnt), 32'd4);
    bus.brightness = 4'd0;
    on_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick_n(1);
      if (bus.led != 8'h00) on_cnt++;
    end
    chk("pwm0_on", 32'(on_cnt), 32'd0);
`else
    on_cnt = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
